// File: rtl/bpsk_frame_ctrl.sv
// bpsk_frame_ctrl: frame sequencer for the BPSK transmit chain.
// Generates a clk_sig-domain symbol strobe and builds each frame as
// preamble (1,0,1,0,...), sync word (MSB first), m-series payload, then a
// muted guard. Drives the bit fed to bpsk and gates the duc output.
//
// Ports:
//   clk_sig    in   system clock (carrier/duc rate)
//   rst_sig    in   synchronous reset, active-high
//   start      in   request one frame; sampled only in IDLE
//   cont       in   sampled at the last guard cycle: 1 = next frame with no gap
//   abort      in   terminate the frame; back to IDLE next cycle
//   pn_bit     in   current m-series bit
//   pn_adv     out  one-cycle pulse: pn_bit consumed, source advances
//   sym_stb    out  one-cycle pulse on the last cycle of every symbol
//   base_sig   out  symbol bit to bpsk, constant for SPS cycles
//   tx_en      out  duc output valid (0 gates the output to zero)
//   busy       out  high in every state except IDLE
//   frame_done out  one-cycle pulse on the last guard cycle
module bpsk_frame_ctrl #(
  parameter int unsigned SPS       = 1280,
  parameter int unsigned PRE_LEN   = 16,
  parameter int unsigned SYNC_LEN  = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 16'hF5A3,
  parameter int unsigned PAY_LEN   = 127,
  parameter int unsigned GUARD_LEN = 4
) (
  input  logic clk_sig,
  input  logic rst_sig,
  input  logic start,
  input  logic cont,
  input  logic abort,
  input  logic pn_bit,
  output logic pn_adv,
  output logic sym_stb,
  output logic base_sig,
  output logic tx_en,
  output logic busy,
  output logic frame_done
);

  localparam int unsigned SW      = $clog2(SPS);
  localparam int unsigned MAX_A   = (PRE_LEN > SYNC_LEN) ? PRE_LEN : SYNC_LEN;
  localparam int unsigned MAX_B   = (PAY_LEN > GUARD_LEN) ? PAY_LEN : GUARD_LEN;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned BW      = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY, GUARD} state_t;

  state_t         state;
  state_t         adv_state;
  logic [SW-1:0]  sym_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [BW-1:0]  adv_bit;
  logic [BW-1:0]  sync_idx;
  logic           last_sym;
  logic           adv_base;

  // State, bit index and symbol value that take effect at the next symbol boundary
  always_comb begin
    last_sym  = 1'b0;
    adv_state = state;
    adv_bit   = bit_cnt + BW'(1);
    adv_base  = 1'b0;
    sync_idx  = '0;

    case (state)
      PRE:     last_sym = (bit_cnt == BW'(PRE_LEN - 1));
      SYNC:    last_sym = (bit_cnt == BW'(SYNC_LEN - 1));
      PAY:     last_sym = (bit_cnt == BW'(PAY_LEN - 1));
      GUARD:   last_sym = (bit_cnt == BW'(GUARD_LEN - 1));
      default: last_sym = 1'b0;
    endcase

    if (last_sym) begin
      adv_bit = '0;
      case (state)
        PRE:     adv_state = SYNC;
        SYNC:    adv_state = PAY;
        PAY:     adv_state = GUARD;
        GUARD:   adv_state = cont ? PRE : IDLE;
        default: adv_state = IDLE;
      endcase
    end

    sync_idx = BW'(SYNC_LEN - 1) - adv_bit;
    case (adv_state)
      PRE:     adv_base = ~adv_bit[0];
      SYNC:    adv_base = 1'(SYNC_WORD >> sync_idx);
      PAY:     adv_base = pn_bit;
      default: adv_base = 1'b0;
    endcase
  end

  // Sequencer: state, counters and all registered outputs
  always_ff @(posedge clk_sig) begin
    if (rst_sig || abort) begin
      // abort shares the reset path so it wins over start, cont and strobes
      state      <= IDLE;
      sym_cnt    <= '0;
      bit_cnt    <= '0;
      pn_adv     <= 1'b0;
      sym_stb    <= 1'b0;
      base_sig   <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pn_adv     <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state    <= PRE;
          sym_cnt  <= '0;
          bit_cnt  <= '0;
          base_sig <= 1'b1;
          tx_en    <= 1'b1;
          busy     <= 1'b1;
          sym_stb  <= 1'b0;
        end
      end else begin
        // strobe is registered one cycle early so it lines up with sym_cnt==SPS-1
        sym_stb    <= (sym_cnt == SW'(SPS - 2));
        frame_done <= (state == GUARD) && last_sym && (sym_cnt == SW'(SPS - 2));
        if (sym_stb) begin
          sym_cnt  <= '0;
          state    <= adv_state;
          bit_cnt  <= adv_bit;
          base_sig <= adv_base;
          tx_en    <= (adv_state == PRE) || (adv_state == SYNC) || (adv_state == PAY);
          busy     <= (adv_state != IDLE);
          pn_adv   <= (adv_state == PAY);
        end else begin
          sym_cnt  <= sym_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// tb_bpsk_frame_ctrl: directed/randomized bench for bpsk_frame_ctrl.
// Payload bits come from a random stream consumed on pn_adv; each frame is
// compared cycle by cycle against a symbol-level model of the frame layout.
module tb_bpsk_frame_ctrl;

  localparam int SPS   = 4;
  localparam int PRE   = 4;
  localparam int SYNC  = 8;
  localparam int PAY   = 7;
  localparam int GUARD = 2;
  localparam int FRAME = (PRE + SYNC + PAY + GUARD) * SPS;
  localparam logic [7:0] SWORD = 8'hA5;

  logic clk = 1'b0;
  logic rst_sig, start, cont, abort, pn_bit;
  logic pn_adv, sym_stb, base_sig, tx_en, busy, frame_done;

  logic pn_stream [256];
  int   pn_idx   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  bpsk_frame_ctrl #(
    .SPS(SPS), .PRE_LEN(PRE), .SYNC_LEN(SYNC), .SYNC_WORD(SWORD),
    .PAY_LEN(PAY), .GUARD_LEN(GUARD)
  ) dut (
    .clk_sig(clk), .rst_sig(rst_sig), .start(start), .cont(cont),
    .abort(abort), .pn_bit(pn_bit), .pn_adv(pn_adv), .sym_stb(sym_stb),
    .base_sig(base_sig), .tx_en(tx_en), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // payload source: present the next stream bit, advance when consumed
  assign pn_bit = pn_stream[8'(pn_idx)];
  always @(posedge clk) if (pn_adv === 1'b1) pn_idx <= pn_idx + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k, input logic eb, input logic etx,
                            input logic ebusy, input logic estb, input logic eadv,
                            input logic edone);
    check1({tag, ".base_sig"},   k, base_sig,   eb);
    check1({tag, ".tx_en"},      k, tx_en,      etx);
    check1({tag, ".busy"},       k, busy,       ebusy);
    check1({tag, ".sym_stb"},    k, sym_stb,    estb);
    check1({tag, ".pn_adv"},     k, pn_adv,     eadv);
    check1({tag, ".frame_done"}, k, frame_done, edone);
  endtask

  // Expected outputs at cycle k (1..FRAME) of a frame whose payload starts at stream index p0
  task automatic model(input int k, input int p0, output logic b, output logic tx,
                       output logic stb, output logic adv, output logic done);
    int s, c;
    logic [7:0] sw;
    sw   = SWORD;
    s    = (k - 1) / SPS;
    c    = (k - 1) % SPS;
    stb  = (c == SPS - 1);
    done = (k == FRAME);
    adv  = 1'b0;
    if (s < PRE) begin
      b  = ((s % 2) == 0);
      tx = 1'b1;
    end else if (s < PRE + SYNC) begin
      b  = sw[3'(7 - (s - PRE))];
      tx = 1'b1;
    end else if (s < PRE + SYNC + PAY) begin
      b   = pn_stream[8'(p0 + s - PRE - SYNC)];
      tx  = 1'b1;
      adv = (c == 0);
    end else begin
      b  = 1'b0;
      tx = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs(tag, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One frame: optional start pulse, optional start noise in PAY, optional abort/reset at stop_k
  task automatic run_frame(input string tag, input bit do_start, input bit cont_val,
                           input bit noise, input int stop_k, input bit stop_rst);
    int p0, ntx, nadv, ndone;
    logic eb, etx, estb, eadv, edone;
    p0 = pn_idx; ntx = 0; nadv = 0; ndone = 0;
    if (do_start) start = 1'b1;
    tick();
    start = 1'b0;
    cont  = cont_val;
    for (int k = 1; k <= FRAME; k++) begin
      if (k > 1) tick();
      model(k, p0, eb, etx, estb, eadv, edone);
      check_outs(tag, k, eb, etx, 1'b1, estb, eadv, edone);
      ntx   += int'(tx_en);
      nadv  += int'(pn_adv);
      ndone += int'(frame_done);
      start = (noise && k >= 48 && k < 76) ? 1'($urandom) : 1'b0;
      if (k == stop_k) begin
        if (stop_rst) rst_sig = 1'b1;
        else begin
          abort = 1'b1;
          start = 1'b1;
        end
        tick();
        check_outs({tag, ".stop"}, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_sig = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check_int({tag, ".tx_en_cycles"},  ntx,   (PRE + SYNC + PAY) * SPS);
    check_int({tag, ".pn_adv_pulses"}, nadv,  PAY);
    check_int({tag, ".frame_done_cnt"}, ndone, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pn_stream[i] = 1'($urandom);
    rst_sig = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    abort   = 1'b0;

    // reset held three cycles, then quiet IDLE
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_sig = 1'b0;
    idle_check("idle", 20);

    // nominal frame
    run_frame("nominal", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_check("post_nominal", 3);

    // back-to-back frames with cont held high through the first
    cont = 1'b1;
    run_frame("cont1", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_frame("cont2", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_check("post_cont", 3);

    // abort with start during sync symbol 2, then a fresh frame
    run_frame("abort", 1'b1, 1'b0, 1'b0, 25 + int'($urandom_range(0, 3)), 1'b0);
    idle_check("post_abort", 4);
    run_frame("after_abort", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_check("post_after_abort", 2);

    // random start pulses during payload are ignored
    run_frame("start_noise", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    idle_check("post_noise", 6);

    // reset during payload, then a full frame
    run_frame("rst_pay", 1'b1, 1'b0, 1'b0, 49 + int'($urandom_range(0, 27)), 1'b1);
    idle_check("post_rst", 2);
    run_frame("after_rst", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_check("final", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
